// File: rtl/pc_call_stack.sv
// pc_call_stack: fetch-stage program counter with a hardware return-address
// stack. Commands are prioritised ret > call > load > branch > increment.
// A stall holds every register. Reset is synchronous and active low.
module pc_call_stack #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int STEP       = 1,
  parameter int RESET_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     load,
  input  logic                     increment,
  input  logic                     branch,
  input  logic                     call,
  input  logic                     ret,
  input  logic [WIDTH-1:0]         addr,
  input  logic [WIDTH-1:0]         offset,
  output logic [WIDTH-1:0]         count,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     err_ovf,
  output logic                     err_unf
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W    = WIDTH'(RESET_ADDR);
  localparam logic [PW:0]      FULL_CNT   = (PW+1)'(DEPTH);
  localparam logic [PW:0]      DEPTH_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0]    INDEX_ONE  = PW'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW:0]      depth_q, depth_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic [WIDTH-1:0] next_seq;
  logic [PW-1:0]    push_idx;
  logic [PW-1:0]    top_idx;
  logic             full_now;
  logic             empty_now;

  // Decode the stack state and the fall-through address used by several commands.
  always_comb begin
    next_seq  = count_q + STEP_W;
    full_now  = (depth_q == FULL_CNT);
    empty_now = (depth_q == '0);
    push_idx  = depth_q[PW-1:0];
    top_idx   = depth_q[PW-1:0] - INDEX_ONE;
  end

  // Next-state selection: stall freezes everything, otherwise the highest-priority command acts.
  always_comb begin
    count_d   = count_q;
    depth_d   = depth_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    stack_d   = stack_q;
    if (!stall) begin
      if (ret) begin
        if (empty_now) begin
          count_d   = next_seq;
          err_unf_d = 1'b1;
        end else begin
          count_d = stack_q[top_idx];
          depth_d = depth_q - DEPTH_ONE;
        end
      end else if (call) begin
        count_d = addr;
        if (full_now) begin
          err_ovf_d = 1'b1;
        end else begin
          stack_d[push_idx] = next_seq;
          depth_d           = depth_q + DEPTH_ONE;
        end
      end else if (load) begin
        count_d = addr;
      end else if (branch) begin
        count_d = count_q + offset;
      end else if (increment) begin
        count_d = next_seq;
      end
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= RESET_W;
      depth_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      depth_q   <= depth_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // Return-address storage; contents are meaningless while depth is zero, so no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign count       = count_q;
  assign depth       = depth_q;
  assign stack_full  = full_now;
  assign stack_empty = empty_now;
  assign err_ovf     = err_ovf_q;
  assign err_unf     = err_unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: table-driven directed test of pc_call_stack at the
// default parameters (WIDTH=16, DEPTH=4, STEP=1, RESET_ADDR=0).
module tb_pc_call_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              load;
  logic              increment;
  logic              branch;
  logic              call;
  logic              ret;
  logic [WIDTH-1:0]  addr;
  logic [WIDTH-1:0]  offset;
  logic [WIDTH-1:0]  count;
  logic [2:0]        depth;
  logic              stack_full;
  logic              stack_empty;
  logic              err_ovf;
  logic              err_unf;

  int checks;
  int failures;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        ret;
    logic        call;
    logic        load;
    logic        branch;
    logic        inc;
    logic [15:0] addr;
    logic [15:0] offset;
    logic [15:0] e_count;
    int          e_depth;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vecs[$];

  pc_call_stack #(
    .WIDTH(16), .DEPTH(4), .STEP(1), .RESET_ADDR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .load(load),
    .increment(increment), .branch(branch), .call(call), .ret(ret),
    .addr(addr), .offset(offset), .count(count), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, clock it in, and settle just past the edge.
  task automatic applyStimulus(input vec_t v);
    rst_n     = v.rst_n;
    stall     = v.stall;
    ret       = v.ret;
    call      = v.call;
    load      = v.load;
    branch    = v.branch;
    increment = v.inc;
    addr      = v.addr;
    offset    = v.offset;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input string field,
                          input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%04h required=0x%04h", name, field, act, exp);
    end
  endtask

  // Compare every output against the expected state; full/empty follow from depth.
  task automatic checkOutput(input string name, input logic [15:0] e_count,
                             input int e_depth, input logic e_ovf, input logic e_unf);
    checkOne(name, "count", count, e_count);
    checkOne(name, "depth", 16'(depth), 16'(e_depth));
    checkOne(name, "full",  16'(stack_full),  16'(e_depth == DEPTH));
    checkOne(name, "empty", 16'(stack_empty), 16'(e_depth == 0));
    checkOne(name, "ovf",   16'(err_ovf), 16'(e_ovf));
    checkOne(name, "unf",   16'(err_unf), 16'(e_unf));
  endtask

  function automatic vec_t mk(logic r, logic s, logic rt, logic c, logic l, logic b,
                              logic i, logic [15:0] a, logic [15:0] o,
                              logic [15:0] ec, int ed, logic eo, logic eu);
    vec_t v;
    v.rst_n = r;  v.stall = s;   v.ret = rt;  v.call = c;
    v.load = l;   v.branch = b;  v.inc = i;   v.addr = a;  v.offset = o;
    v.e_count = ec; v.e_depth = ed; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  initial begin
    vec_t idle;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0; stall = 1'b0; load = 1'b0; increment = 1'b0;
    branch = 1'b0; call = 1'b0; ret = 1'b0; addr = '0; offset = '0;

    //                rst s  rt c  l  b  i  addr     offset   count    d  ovf unf
    // reset with a competing load
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0));
    // increment across the 16-bit wrap
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 16'hFFFE, 16'h0000, 16'hFFFE, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0));
    // signed branch backwards then forwards
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 16'h0100, 16'h0000, 16'h0100, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 16'h0000, 16'hFFF0, 16'h00F0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0010, 16'h0100, 0, 0, 0));
    // nested call / return
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0010, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h0200, 16'h0000, 16'h0200, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h0300, 16'h0000, 16'h0300, 2, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0201, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0));
    // return from empty falls through and sets sticky underflow
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0012, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0013, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0013, 0, 0, 1));
    // fill the stack, then overflow: the jump is still taken
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h1000, 16'h0000, 16'h1000, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h2000, 16'h0000, 16'h2000, 2, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h3000, 16'h0000, 16'h3000, 3, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h4000, 16'h0000, 16'h4000, 4, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h5000, 16'h0000, 16'h5000, 4, 1, 1));
    // ret beats call and load; stall holds everything
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 16'h7777, 16'h0000, 16'h3001, 3, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h3001, 3, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 16'h0ABC, 16'h0000, 16'h3001, 3, 1, 1));
    // branch beats increment, load beats branch
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0002, 16'h3003, 3, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 16'h0AAA, 16'h0005, 16'h0AAA, 3, 1, 1));
    // unwind the remaining entries
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h2001, 2, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1001, 1, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0014, 0, 1, 1));
    // reset with a competing call clears the sticky errors
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 16'h4444, 16'h0000, 16'h0000, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_depth,
                  vecs[i].e_ovf, vecs[i].e_unf);
    end

    idle = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

    // Pushed return address wraps: call from 0xFFFF stores 0x0000.
    begin
      vec_t v;
      v = idle; v.load = 1'b1; v.addr = 16'hFFFF;
      applyStimulus(v);
      v = idle; v.call = 1'b1; v.addr = 16'h0040;
      applyStimulus(v);
      checkOutput("wrap_call", 16'h0040, 1, 1'b0, 1'b0);
      v = idle; v.ret = 1'b1;
      applyStimulus(v);
      checkOutput("wrap_ret", 16'h0000, 0, 1'b0, 1'b0);
    end

    // Reset in the same cycle as a ret with a non-empty stack.
    begin
      vec_t v;
      v = idle; v.load = 1'b1; v.addr = 16'h0500;
      applyStimulus(v);
      v = idle; v.call = 1'b1; v.addr = 16'h0600;
      applyStimulus(v);
      v = idle; v.call = 1'b1; v.addr = 16'h0700;
      applyStimulus(v);
      checkOutput("pre_rst", 16'h0700, 2, 1'b0, 1'b0);
      v = idle; v.rst_n = 1'b0; v.ret = 1'b1;
      applyStimulus(v);
      checkOutput("rst_mid_ret", 16'h0000, 0, 1'b0, 1'b0);
      // Underflow after reset is still flagged, and survives many idle cycles.
      v = idle; v.ret = 1'b1;
      applyStimulus(v);
      for (int k = 0; k < 5; k++) applyStimulus(idle);
      checkOutput("unf_sticky", 16'h0001, 0, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
